alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_regfile.sv | 29 ++
 rtl/alu_seq_ctrl.sv | 113 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and instruction-field types for the sequenced ALU controller.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_EOR = 3'd4,
    OP_BIC = 3'd5,
    OP_RSB = 3'd6,
    OP_BEQ = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // rb is taken from imm[1:0] when use_imm is clear.
  typedef struct packed {
    alu_op_t    op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic       use_imm;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 operand register file: two combinational read ports, one write port, sync reset to REG_INIT.
module alu_seq_regfile #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_ra_addr,
  input  logic [1:0] i_rb_addr,
  output logic [7:0] o_ra_dat,
  output logic [7:0] o_rb_dat,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [7:0] i_wr_dat
);

  logic [7:0] r_mem [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= REG_INIT;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_ra_dat = r_mem[i_ra_addr];
  assign o_rb_dat = r_mem[i_rb_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one instruction at a time through an external ALU: accept -> EXEC -> RESP, result valid 2 cycles after accept,
// held until res_ready; no new accept until RESP completes. ALU_SEQ_ZFLAG_EN adds the res_zero output.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [7:0]  alu_out,
  input  logic        alu_eq,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_eq
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic        res_zero
`endif
);

  state_t     r_state;
  state_t     w_next_state;
  instr_t     r_instr;
  logic [7:0] r_res_data;
  logic       r_res_eq;
  logic       w_wr_en;
  logic [7:0] w_ra_dat;
  logic [7:0] w_rb_dat;

  alu_seq_regfile #(
    .REG_INIT (REG_INIT)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_ra_addr (r_instr.ra),
    .i_rb_addr (r_instr.imm[1:0]),
    .o_ra_dat  (w_ra_dat),
    .o_rb_dat  (w_rb_dat),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_instr.rd),
    .i_wr_dat  (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_ctrl     = 3'd0;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        alu_ctrl     = r_instr.op;
        alu_a        = w_ra_dat;
        alu_b        = r_instr.use_imm ? r_instr.imm : w_rb_dat;
        w_wr_en      = (r_instr.op != OP_BEQ);
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operands are read combinationally in EXEC, so the same-edge write to rd never affects them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= '0;
      r_res_data <= 8'h00;
      r_res_eq   <= 1'b0;
    end else begin
      if (in_valid && in_ready) r_instr <= instr_t'(in_instr);
      if (r_state == ST_EXEC) begin
        if (r_instr.op == OP_BEQ) r_res_eq   <= alu_eq;
        else                      r_res_data <= alu_out;
      end
    end
  end

  assign res_data = r_res_data;
  assign res_eq   = r_res_eq;

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_res_zero;

  always_ff @(posedge clk) begin
    if (rst)          r_res_zero <= 1'b0;
    else if (w_wr_en) r_res_zero <= (alu_out == 8'h00);
  end

  assign res_zero = r_res_zero;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU and an expected-result queue.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_ctrl;
  logic [7:0]  alu_out;
  logic        alu_eq;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_eq;
`ifdef ALU_SEQ_ZFLAG_EN
  logic        res_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       z;
  } exp_t;

  exp_t exp_q[$];

  alu_seq_ctrl #(.REG_INIT(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_eq    (alu_eq),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_eq    (res_eq)
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    .res_zero  (res_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out = 8'h00;
    case (alu_ctrl)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_EOR:  alu_out = alu_a ^ alu_b;
      OP_BIC:  alu_out = alu_a & ~alu_b;
      OP_RSB:  alu_out = alu_b - alu_a;
      default: alu_out = 8'h00;
    endcase
    alu_eq = (alu_a == alu_b);
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic ui, input logic [7:0] imm);
    return {op, rd, ra, ui, imm};
  endfunction

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Would overwrite R0 with 04 if it were ever accepted while busy.
  localparam logic [15:0] JUNK = 16'h01FF;

  task automatic run(input logic [15:0] ins, input logic [7:0] ed, input logic ee,
                     input logic ez, input int stall);
    exp_t ex;
    in_instr  = ins;
    in_valid  = 1'b1;
    res_ready = 1'b0;
    check1("accept_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({ed, ee, ez});
    check1("exec_busy", in_ready, 1'b0);
    check1("exec_novld", res_valid, 1'b0);
    check8("exec_ctrl", {5'd0, alu_ctrl}, {5'd0, ins[15:13]});
    @(posedge clk); #1;
    check1("lat2_vld", res_valid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_instr = JUNK;
      @(posedge clk); #1;
      check1("stall_vld", res_valid, 1'b1);
      check1("stall_rdy", in_ready, 1'b0);
      check8("stall_data", res_data, exp_q[0].d);
    end
    in_valid = 1'b0;
    check1("resp_vld", res_valid, 1'b1);
    ex = exp_q.pop_front();
    check8("res_data", res_data, ex.d);
    check1("res_eq", res_eq, ex.e);
`ifdef ALU_SEQ_ZFLAG_EN
    check1("res_zero", res_zero, ex.z);
`endif
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check1("back_idle", in_ready, 1'b1);
    check1("vld_drop", res_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_res_valid", res_valid, 1'b0);
    check8("rst_res_data", res_data, 8'h00);
    check1("rst_res_eq", res_eq, 1'b0);
    check8("rst_alu_a", alu_a, 8'h00);
    check8("rst_alu_b", alu_b, 8'h00);
    check8("rst_alu_ctrl", {5'd0, alu_ctrl}, 8'h00);

    run(mk(OP_ADD, 2'd0, 2'd0, 1'b1, 8'h05), 8'h05, 1'b0, 1'b0, 0);
    run(mk(OP_SUB, 2'd1, 2'd0, 1'b1, 8'h07), 8'hFE, 1'b0, 1'b0, 5);
    run(mk(OP_OR,  2'd1, 2'd0, 1'b1, 8'h00), 8'h05, 1'b0, 1'b0, 0);
    run(mk(OP_BEQ, 2'd0, 2'd0, 1'b0, 8'h01), 8'h05, 1'b1, 1'b0, 0);
    run(mk(OP_OR,  2'd2, 2'd1, 1'b1, 8'h00), 8'h05, 1'b1, 1'b0, 0);
    run(mk(OP_BEQ, 2'd0, 2'd0, 1'b1, 8'h06), 8'h05, 1'b0, 1'b0, 0);
    run(mk(OP_RSB, 2'd3, 2'd0, 1'b1, 8'h05), 8'h00, 1'b0, 1'b1, 0);
    run(mk(OP_BEQ, 2'd0, 2'd3, 1'b1, 8'h00), 8'h00, 1'b1, 1'b1, 0);
    run(mk(OP_EOR, 2'd2, 2'd2, 1'b1, 8'hFF), 8'hFA, 1'b1, 1'b0, 0);
    run(mk(OP_BIC, 2'd3, 2'd2, 1'b1, 8'hF0), 8'h0A, 1'b1, 1'b0, 0);
    run(mk(OP_AND, 2'd0, 2'd2, 1'b0, 8'h01), 8'h00, 1'b1, 1'b1, 0);

    // Reset while an ADD to R2 sits in EXEC: nothing written, no response.
    in_instr = mk(OP_ADD, 2'd2, 2'd2, 1'b1, 8'h01);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("rstx_in_exec", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check1("rstx_res_valid", res_valid, 1'b0);
    check1("rstx_in_ready", in_ready, 1'b1);
    check8("rstx_res_data", res_data, 8'h00);
    check1("rstx_res_eq", res_eq, 1'b0);
    @(posedge clk); #1;
    check1("rstx_no_resp", res_valid, 1'b0);

    run(mk(OP_OR,  2'd0, 2'd2, 1'b1, 8'h00), 8'h00, 1'b0, 1'b1, 0);
    run(mk(OP_ADD, 2'd1, 2'd1, 1'b1, 8'h03), 8'h03, 1'b0, 1'b0, 0);

    check8("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
